buzzer_tone_generator: RTL and testbench

BUZZER_TONE_GENERATOR -- requirements
Module: buzzer_tone_generator

---
 rtl/buzzer_pkg.sv | 19 +
 rtl/buzzer_tone_generator.sv | 114 +++++++++++
 tb/tb_buzzer_tone_generator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer tone generator: FSM state encodings,
// bus register bit positions and the counter width helper.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TONE  = 2'd1,
    DRAIN = 2'd2
  } buzz_state_e;

  localparam int CTRL_EN_BIT   = 0;
  localparam int DATA_BUZZ_BIT = 0;

  // Width needed for a counter that cycles through n values (0..n-1), at least 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buzzer_tone_generator.sv
// Piezo square-wave generator with a guaranteed minimum beep length and
// a graceful stop that always finishes the current half-period.
module buzzer_tone_generator
  import buzzer_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TONE_FREQ   = 2_000,
  parameter int MIN_BEEP_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ctrl_en,
  input  logic ctrl_buzz,
  output logic buzzer_out,
  output logic busy
);

  localparam int HALF_PERIOD = CLK_FREQ / (2 * TONE_FREQ);
  localparam int MIN_ON      = (CLK_FREQ / 1000) * MIN_BEEP_MS;
  localparam int PH_W        = cnt_w(HALF_PERIOD);
  localparam int MO_W        = cnt_w(MIN_ON);

  if (HALF_PERIOD < 1 || MIN_ON < 1) begin : g_bad_params
    $error("buzzer_tone_generator: HALF_PERIOD and MIN_ON must both be at least 1");
  end

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [MO_W-1:0] MO_LOAD = MO_W'(MIN_ON - 1);

  buzz_state_e     state_q,      state_d;
  logic [PH_W-1:0] phase_q,      phase_d;
  logic [MO_W-1:0] min_q,        min_d;
  logic            buzzer_out_q, buzzer_out_d;

  logic            request;
  logic            boundary;
  logic [PH_W-1:0] phase_next;

  always_comb begin
    request    = ctrl_en && ctrl_buzz;
    boundary   = (phase_q == PH_LAST);
    phase_next = boundary ? '0 : phase_q + PH_W'(1);

    state_d      = state_q;
    phase_d      = phase_q;
    min_d        = min_q;
    buzzer_out_d = buzzer_out_q;

    if (!ctrl_en) begin
      // Disable wins over everything, even a coincident boundary toggle.
      state_d      = IDLE;
      phase_d      = '0;
      min_d        = '0;
      buzzer_out_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          phase_d      = '0;
          min_d        = '0;
          buzzer_out_d = 1'b0;
          if (request) begin
            state_d      = TONE;
            buzzer_out_d = 1'b1;
            min_d        = MO_LOAD;
          end
        end
        TONE: begin
          phase_d = phase_next;
          min_d   = (min_q == '0) ? '0 : min_q - MO_W'(1);
          if (boundary) buzzer_out_d = ~buzzer_out_q;
          if (!ctrl_buzz && min_q == '0) state_d = DRAIN;
        end
        DRAIN: begin
          phase_d = phase_next;
          min_d   = '0;
          if (request) begin
            // Re-trigger keeps the running phase so the cadence is unbroken.
            state_d = TONE;
            min_d   = MO_LOAD;
            if (boundary) buzzer_out_d = ~buzzer_out_q;
          end else if (boundary) begin
            state_d      = IDLE;
            phase_d      = '0;
            buzzer_out_d = 1'b0;
          end
        end
        default: begin
          state_d      = IDLE;
          phase_d      = '0;
          min_d        = '0;
          buzzer_out_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      min_q        <= '0;
      buzzer_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      min_q        <= min_d;
      buzzer_out_q <= buzzer_out_d;
    end
  end

  assign buzzer_out = buzzer_out_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_buzzer_tone_generator.sv
// Directed scenarios plus randomized traffic for buzzer_tone_generator,
// compared cycle by cycle against a behavioural beep model.
module tb_buzzer_tone_generator;

  localparam int CLK_FREQ    = 1000;
  localparam int TONE_FREQ   = 100;
  localparam int MIN_BEEP_MS = 10;
  localparam int HP          = 5;
  localparam int MIN_ON      = 10;

  logic clk, rst, ctrl_en, ctrl_buzz;
  logic buzzer_out, busy;

  buzzer_tone_generator #(
    .CLK_FREQ   (CLK_FREQ),
    .TONE_FREQ  (TONE_FREQ),
    .MIN_BEEP_MS(MIN_BEEP_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_en   (ctrl_en),
    .ctrl_buzz (ctrl_buzz),
    .buzzer_out(buzzer_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: a beep is "sounding" from its start; age counts cycles
  // since the start, so the square-wave phase is simply age % HP.
  int m_on, m_stop, m_lvl, m_age, m_hold;

  int cyc = 0;
  int last_toggle = -1;
  int cadence_on = 0;
  logic prev_out = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_stop = 0; m_lvl = 0; m_age = 0; m_hold = 0;
  endtask

  task automatic model_step(input logic en, input logic bz);
    int bnd;
    if (!en) begin
      model_reset();
    end else if (m_on == 0) begin
      if (bz) begin
        m_on = 1; m_stop = 0; m_lvl = 1; m_age = 0; m_hold = MIN_ON - 1;
      end
    end else begin
      bnd = ((m_age % HP) == HP - 1);
      m_age++;
      if (m_stop == 0) begin
        if (bnd) m_lvl = !m_lvl;
        if (!bz && m_hold == 0) m_stop = 1;
        if (m_hold > 0) m_hold--;
      end else if (bz) begin
        m_stop = 0;
        m_hold = MIN_ON - 1;
        if (bnd) m_lvl = !m_lvl;
      end else if (bnd) begin
        model_reset();
      end
    end
  endtask

  task automatic step(input logic en, input logic bz);
    ctrl_en = en;
    ctrl_buzz = bz;
    @(posedge clk);
    model_step(en, bz);
    #1;
    cyc++;
    check("out", buzzer_out, m_lvl);
    check("busy", busy, m_on);
    if (buzzer_out !== prev_out) begin
      if (cadence_on != 0 && last_toggle >= 0) check("cadence", cyc - last_toggle, HP);
      last_toggle = cyc;
    end
    prev_out = buzzer_out;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_out", buzzer_out, 0);
    check("rst_busy", busy, 0);
    #1 rst = 1'b0;
    prev_out = 1'b0;
    last_toggle = -1;
  endtask

  initial begin
    int n;
    int hit;
    logic bz_r;

    rst = 1'b1; ctrl_en = 1'b0; ctrl_buzz = 1'b0;
    model_reset();
    #2;
    check("reset_out", buzzer_out, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Steady tone
    cadence_on = 1;
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    cadence_on = 0;
    last_toggle = -1;
    check("steady_idle", busy, 0);

    // Short 1-cycle pulse
    step(1'b1, 1'b1);
    check("pulse_start", buzzer_out, 1);
    n = 1;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      if (busy === 1'b0) begin hit = 1; break; end
      n++;
    end
    check("pulse_ended", hit, 1);
    check("pulse_len_ok", (n >= MIN_ON) ? 1 : 0, 1);
    check("pulse_silent", buzzer_out, 0);

    // Graceful stop two cycles into a high half-period
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_lvl == 1 && (m_age % HP) == 1) begin hit = 1; break; end
      step(1'b1, 1'b1);
    end
    check("stop_aligned", hit, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (buzzer_out === 1'b1) n++;
      else break;
    end
    check("stop_high_cycles", n, 3);
    check("stop_idle", busy, 0);

    // Abort coincident with a boundary during a high phase
    step(1'b1, 1'b1);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_lvl == 1 && (m_age % HP) == HP - 1 && m_age >= 2 * HP) begin hit = 1; break; end
      step(1'b1, 1'b1);
    end
    check("abort_aligned", hit, 1);
    step(1'b0, 1'b1);
    check("abort_out", buzzer_out, 0);
    check("abort_busy", busy, 0);

    // Re-trigger during DRAIN
    cadence_on = 1;
    last_toggle = -1;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      if ((m_age % HP) == 0) begin hit = 1; break; end
      step(1'b1, 1'b1);
    end
    check("drain_aligned", hit, 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("drain_busy", busy, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    // Released right away: the restarted minimum-on time must still hold the tone.
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0);
      if (busy === 1'b0) break;
      n++;
    end
    check("retrig_hold", (n >= MIN_ON - 3) ? 1 : 0, 1);
    cadence_on = 0;

    // Async reset mid-tone, request held through and after release
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    async_reset();
    step(1'b1, 1'b1);
    check("restart_out", buzzer_out, 1);
    check("restart_busy", busy, 1);

    // Randomized traffic
    bz_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) bz_r = !bz_r;
      step(($urandom_range(0, 29) != 0), bz_r);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
